pc_stack: RTL and testbench

PC_STACK -- requirements
Module: pc_stack

---
 rtl/pc_stack_pkg.sv | 37 +++
 rtl/pc_stack_lifo.sv | 71 +++++++
 rtl/pc_stack.sv | 162 ++++++++++++++++
 tb/tb_pc_stack.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_stack_pkg.sv
// -----------------------------------------------------------------------------
// pc_stack_pkg
// Shared definitions for the program counter with return-address stack:
//   - default address width and stack depth
//   - command encoding, numerically ordered by priority (CMD_CLR highest)
//   - decode_cmd(): collapses the raw command inputs to the single winning cmd
// -----------------------------------------------------------------------------
package pc_stack_pkg;

  localparam int DEF_ADDR_WIDTH  = 8;
  localparam int DEF_STACK_DEPTH = 8;

  typedef enum logic [2:0] {
    CMD_NONE = 3'd0,
    CMD_INC  = 3'd1,
    CMD_LOAD = 3'd2,
    CMD_CALL = 3'd3,
    CMD_RET  = 3'd4,
    CMD_CLR  = 3'd5
  } cmd_e;

  // Only the highest-priority asserted command survives; lower ones are dropped
  // silently (a call alongside a ret is not an error).
  function automatic cmd_e decode_cmd(input logic clr,
                                      input logic ret,
                                      input logic call,
                                      input logic load,
                                      input logic inc);
    if (clr)       return CMD_CLR;
    else if (ret)  return CMD_RET;
    else if (call) return CMD_CALL;
    else if (load) return CMD_LOAD;
    else if (inc)  return CMD_INC;
    else           return CMD_NONE;
  endfunction

endpackage : pc_stack_pkg

// File: rtl/pc_stack_lifo.sv
// -----------------------------------------------------------------------------
// addr_lifo
// Register-based LIFO of return addresses.
//   clk        in  clock, rising edge
//   a_reset_n  in  asynchronous active-low reset (level only; entries untouched)
//   i_clr      in  synchronous clear of the level (entries untouched)
//   i_push     in  push i_push_data (ignored when full)
//   i_pop      in  discard top entry (ignored when empty)
//   i_push_data in DATA_WIDTH value to push
//   o_top      out entry at the top (meaningless when level == 0)
//   o_level    out number of occupied entries, 0..DEPTH
// Priority inside the LIFO: clr > pop > push.
// -----------------------------------------------------------------------------
module addr_lifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic                      clk,
  input  logic                      a_reset_n,
  input  logic                      i_clr,
  input  logic                      i_push,
  input  logic                      i_pop,
  input  logic [DATA_WIDTH-1:0]     i_push_data,
  output logic [DATA_WIDTH-1:0]     o_top,
  output logic [$clog2(DEPTH):0]    o_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [LVL_W-1:0]      r_level;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_do_push;
  logic                  w_do_pop;
  logic [PTR_W-1:0]      w_top_idx;

  assign w_full    = (r_level == LVL_W'(DEPTH));
  assign w_empty   = (r_level == '0);
  assign w_do_pop  = !i_clr && i_pop && !w_empty;
  assign w_do_push = !i_clr && !i_pop && i_push && !w_full;

  // Wraps to DEPTH-1 when empty; that read is never used by the counter logic.
  assign w_top_idx = PTR_W'(r_level - LVL_W'(1));
  assign o_top     = r_mem[w_top_idx];
  assign o_level   = r_level;

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values of its inputs, independent of statement order.
  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      r_level <= '0;
    end else if (i_clr) begin
      r_level <= '0;
    end else if (w_do_pop) begin
      r_level <= r_level - LVL_W'(1);
    end else if (w_do_push) begin
      r_level <= r_level + LVL_W'(1);
    end
  end

  // NOTE: the entry array has no reset; an entry is only read after a push
  // has written it, so reset would cost flops for no visible effect.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_level[PTR_W-1:0]] <= i_push_data;
    end
  end

endmodule : addr_lifo

// File: rtl/pc_stack.sv
// -----------------------------------------------------------------------------
// pc_stack
// Program counter with a hardware return-address stack. With call and ret tied
// low it behaves exactly like the plain program counter it replaces.
//   clk           in  clock, rising edge
//   a_reset_n     in  asynchronous active-low reset (pre-synchronised outside)
//   reset         in  synchronous clear of counter, stack and error flags
//   load          in  jump: counter <= load_data
//   load_data     in  jump / call target
//   increment     in  counter <= counter + 1 (saturates, sets out_of_range)
//   call          in  push counter+1, counter <= load_data
//   ret           in  pop top entry into counter
//   counter       out current program address
//   out_of_range  out sticky: increment attempted at the maximum address
//   stack_level   out occupied stack entries
//   stack_full    out stack_level == STACK_DEPTH
//   stack_empty   out stack_level == 0
//   overflow_err  out sticky: call on full stack
//   underflow_err out sticky: ret on empty stack
// Priority: reset > ret > call > load > increment.
// -----------------------------------------------------------------------------
module pc_stack
  import pc_stack_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
  input  logic                          clk,
  input  logic                          a_reset_n,
  input  logic                          reset,
  input  logic                          load,
  input  logic [ADDR_WIDTH-1:0]         load_data,
  input  logic                          increment,
  input  logic                          call,
  input  logic                          ret,
  output logic [ADDR_WIDTH-1:0]         counter,
  output logic                          out_of_range,
  output logic [$clog2(STACK_DEPTH):0]  stack_level,
  output logic                          stack_full,
  output logic                          stack_empty,
  output logic                          overflow_err,
  output logic                          underflow_err
);

  localparam int LVL_W = $clog2(STACK_DEPTH) + 1;

  logic [ADDR_WIDTH-1:0] r_counter;
  logic                  r_oor;
  logic                  r_ovf;
  logic                  r_unf;

  cmd_e                  w_cmd;
  logic [ADDR_WIDTH-1:0] w_counter_nxt;
  logic                  w_oor_nxt;
  logic                  w_ovf_nxt;
  logic                  w_unf_nxt;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_clr;
  logic [ADDR_WIDTH-1:0] w_ret_addr;
  logic [ADDR_WIDTH-1:0] w_top;
  logic [LVL_W-1:0]      w_level;
  logic                  w_full;
  logic                  w_empty;

  // Return address wraps modulo 2^ADDR_WIDTH (a call at the last address
  // returns to 0).
  assign w_ret_addr = r_counter + ADDR_WIDTH'(1);

  // Status flags come only from the level register, never from the inputs.
  assign w_full  = (w_level == LVL_W'(STACK_DEPTH));
  assign w_empty = (w_level == '0);

  assign w_cmd = decode_cmd(reset, ret, call, load, increment);

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    w_counter_nxt = r_counter;
    w_oor_nxt     = r_oor;
    w_ovf_nxt     = r_ovf;
    w_unf_nxt     = r_unf;
    w_push        = 1'b0;
    w_pop         = 1'b0;
    w_clr         = 1'b0;

    unique case (w_cmd)
      CMD_CLR: begin
        w_clr         = 1'b1;
        w_counter_nxt = '0;
        w_oor_nxt     = 1'b0;
        w_ovf_nxt     = 1'b0;
        w_unf_nxt     = 1'b0;
      end
      CMD_RET: begin
        if (w_empty) begin
          w_unf_nxt = 1'b1;
        end else begin
          w_pop         = 1'b1;
          w_counter_nxt = w_top;
        end
      end
      CMD_CALL: begin
        if (w_full) begin
          w_ovf_nxt = 1'b1;
        end else begin
          w_push        = 1'b1;
          w_counter_nxt = load_data;
        end
      end
      CMD_LOAD: begin
        w_counter_nxt = load_data;
      end
      CMD_INC: begin
        if (r_counter == '1) begin
          w_oor_nxt = 1'b1;
        end else begin
          w_counter_nxt = w_ret_addr;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      r_counter <= '0;
      r_oor     <= 1'b0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
    end else begin
      r_counter <= w_counter_nxt;
      r_oor     <= w_oor_nxt;
      r_ovf     <= w_ovf_nxt;
      r_unf     <= w_unf_nxt;
    end
  end

  addr_lifo #(
    .DATA_WIDTH (ADDR_WIDTH),
    .DEPTH      (STACK_DEPTH)
  ) u_lifo (
    .clk         (clk),
    .a_reset_n   (a_reset_n),
    .i_clr       (w_clr),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_push_data (w_ret_addr),
    .o_top       (w_top),
    .o_level     (w_level)
  );

  assign counter       = r_counter;
  assign out_of_range  = r_oor;
  assign stack_level   = w_level;
  assign stack_full    = w_full;
  assign stack_empty   = w_empty;
  assign overflow_err  = r_ovf;
  assign underflow_err = r_unf;

endmodule : pc_stack

// File: tb/tb_pc_stack.sv
// -----------------------------------------------------------------------------
// tb_pc_stack
// Self-checking bench for pc_stack (ADDR_WIDTH=8, STACK_DEPTH=8): a table of
// single-cycle command vectors with hand-computed results, followed by
// hand-written sequences for nested calls/overflow, call+ret collision,
// idle hold and asynchronous reset mid-cycle.
// -----------------------------------------------------------------------------
module tb_pc_stack;

  localparam int AW = 8;
  localparam int SD = 8;

  logic          clk;
  logic          a_reset_n;
  logic          reset;
  logic          load;
  logic [AW-1:0] load_data;
  logic          increment;
  logic          call;
  logic          ret;
  logic [AW-1:0] counter;
  logic          out_of_range;
  logic [3:0]    stack_level;
  logic          stack_full;
  logic          stack_empty;
  logic          overflow_err;
  logic          underflow_err;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic          rst;
    logic          ld;
    logic [AW-1:0] data;
    logic          inc;
    logic          cl;
    logic          rt;
    logic [AW-1:0] e_cnt;
    logic [3:0]    e_lvl;
    logic          e_oor;
    logic          e_ovf;
    logic          e_unf;
  } vec_t;

  vec_t vecs[$];

  pc_stack #(
    .ADDR_WIDTH  (AW),
    .STACK_DEPTH (SD)
  ) dut (
    .clk           (clk),
    .a_reset_n     (a_reset_n),
    .reset         (reset),
    .load          (load),
    .load_data     (load_data),
    .increment     (increment),
    .call          (call),
    .ret           (ret),
    .counter       (counter),
    .out_of_range  (out_of_range),
    .stack_level   (stack_level),
    .stack_full    (stack_full),
    .stack_empty   (stack_empty),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [AW-1:0] e_cnt,
                             input logic [3:0] e_lvl, input logic e_oor,
                             input logic e_ovf, input logic e_unf);
    check({tag, " counter"},       32'(counter),       32'(e_cnt));
    check({tag, " stack_level"},   32'(stack_level),   32'(e_lvl));
    check({tag, " stack_full"},    32'(stack_full),    32'(e_lvl == 4'(SD)));
    check({tag, " stack_empty"},   32'(stack_empty),   32'(e_lvl == 4'd0));
    check({tag, " out_of_range"},  32'(out_of_range),  32'(e_oor));
    check({tag, " overflow_err"},  32'(overflow_err),  32'(e_ovf));
    check({tag, " underflow_err"}, 32'(underflow_err), 32'(e_unf));
  endtask

  task automatic idle_inputs();
    reset = 1'b0; load = 1'b0; load_data = '0;
    increment = 1'b0; call = 1'b0; ret = 1'b0;
  endtask

  // Drive one cycle of commands just after an edge, then sample #1 after the
  // next edge.
  task automatic step(input logic rst, input logic ld, input logic [AW-1:0] data,
                      input logic inc, input logic cl, input logic rt);
    reset = rst; load = ld; load_data = data;
    increment = inc; call = cl; ret = rt;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic add(input logic rst, input logic ld, input logic [AW-1:0] data,
                     input logic inc, input logic cl, input logic rt,
                     input logic [AW-1:0] e_cnt, input logic [3:0] e_lvl,
                     input logic e_oor, input logic e_ovf, input logic e_unf);
    vec_t v;
    v.rst = rst; v.ld = ld; v.data = data; v.inc = inc; v.cl = cl; v.rt = rt;
    v.e_cnt = e_cnt; v.e_lvl = e_lvl; v.e_oor = e_oor; v.e_ovf = e_ovf; v.e_unf = e_unf;
    vecs.push_back(v);
  endtask

  initial begin
    idle_inputs();
    a_reset_n = 1'b0;

    // ---------------- table ----------------
    //   rst ld data   inc cl rt   cnt   lvl oor ovf unf
    add(1, 0, 8'h00, 0, 0, 0,  8'h00, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++)
      add(0, 0, 8'h00, 1, 0, 0, AW'(k), 0, 0, 0, 0);
    add(0, 1, 8'h10, 0, 0, 0,  8'h10, 0, 0, 0, 0);
    add(0, 0, 8'h80, 0, 1, 0,  8'h80, 1, 0, 0, 0);
    for (int k = 1; k <= 3; k++)
      add(0, 0, 8'h00, 1, 0, 0, AW'(8'h80 + k), 1, 0, 0, 0);
    add(0, 0, 8'h00, 0, 0, 1,  8'h11, 0, 0, 0, 0);
    add(0, 1, 8'h22, 0, 0, 0,  8'h22, 0, 0, 0, 0);
    add(0, 0, 8'h00, 0, 0, 1,  8'h22, 0, 0, 0, 1);
    for (int k = 1; k <= 10; k++)
      add(0, 0, 8'h00, 1, 0, 0, AW'(8'h22 + k), 0, 0, 0, 1);
    add(1, 0, 8'h00, 0, 0, 0,  8'h00, 0, 0, 0, 0);
    add(0, 1, 8'hFF, 0, 0, 0,  8'hFF, 0, 0, 0, 0);
    add(0, 0, 8'h00, 1, 0, 0,  8'hFF, 0, 1, 0, 0);
    add(0, 0, 8'h40, 0, 1, 0,  8'h40, 1, 1, 0, 0);
    add(0, 0, 8'h00, 1, 0, 0,  8'h41, 1, 1, 0, 0);
    add(0, 0, 8'h00, 0, 0, 1,  8'h00, 0, 1, 0, 0);
    add(1, 0, 8'h00, 0, 0, 0,  8'h00, 0, 0, 0, 0);
    add(0, 1, 8'h30, 1, 0, 0,  8'h30, 0, 0, 0, 0);
    add(0, 1, 8'h50, 1, 1, 0,  8'h50, 1, 0, 0, 0);
    add(0, 0, 8'h00, 0, 0, 1,  8'h31, 0, 0, 0, 0);
    add(1, 1, 8'h12, 1, 1, 1,  8'h00, 0, 0, 0, 0);
    add(0, 0, 8'h00, 0, 0, 0,  8'h00, 0, 0, 0, 0);

    // Asynchronous reset asserted before any clock activity.
    #2;
    check_state("async_reset_init", 8'h00, 0, 0, 0, 0);
    #10;
    a_reset_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].ld, vecs[i].data, vecs[i].inc, vecs[i].cl, vecs[i].rt);
      check_state($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_lvl,
                  vecs[i].e_oor, vecs[i].e_ovf, vecs[i].e_unf);
    end

    // ---------------- nested calls / overflow / LIFO unwind ----------------
    step(1, 0, 8'h00, 0, 0, 0);
    check_state("nest_reset", 8'h00, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, AW'(8'h10 * (i + 1)), 0, 1, 0);
      check_state($sformatf("nest_call%0d", i), AW'(8'h10 * (i + 1)), 4'(i + 1), 0, 0, 0);
    end
    step(0, 0, 8'h90, 0, 1, 0);
    check_state("nest_call_ovf", 8'h80, 8, 0, 1, 0);
    for (int j = 0; j < 8; j++) begin
      step(0, 0, 8'h00, 0, 0, 1);
      check_state($sformatf("nest_ret%0d", j), AW'(8'h10 * (7 - j) + 1), 4'(7 - j), 0, 1, 0);
    end

    // ---------------- call + ret in the same cycle ----------------
    step(1, 0, 8'h00, 0, 0, 0);
    step(0, 1, 8'h05, 0, 0, 0);
    step(0, 0, 8'h20, 0, 1, 0);
    step(0, 0, 8'h30, 0, 1, 0);
    check_state("collide_pre", 8'h30, 2, 0, 0, 0);
    step(0, 0, 8'h99, 0, 1, 1);
    check_state("collide", 8'h21, 1, 0, 0, 0);

    // ---------------- idle holds all state ----------------
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 8'h00, 0, 0, 0);
      check_state($sformatf("idle%0d", k), 8'h21, 1, 0, 0, 0);
    end

    // ---------------- async reset in the middle of a call ----------------
    call = 1'b1;
    load_data = 8'h77;
    #3;
    a_reset_n = 1'b0;
    #1;
    check_state("async_mid_call", 8'h00, 0, 0, 0, 0);
    #2;
    a_reset_n = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    check_state("after_async", 8'h00, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_pc_stack
